// File: rtl/vec_ser.sv
// Vector serializer: latches a vector of NUM_SLICE slices and emits slices 0..len
// (or len..0) on a valid/ready stream, with no bubble between back-to-back frames.
`timescale 1ns/1ps
module vec_ser #(
  parameter int SLICE_W   = 32,
  parameter int NUM_SLICE = 32,
  parameter int MSB_FIRST = 0,
  localparam int LW = $clog2(NUM_SLICE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SLICE_W*NUM_SLICE-1:0] in_data,
  input  logic [LW-1:0]                in_len,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SLICE_W-1:0]           out_data,
  output logic [LW-1:0]                out_idx,
  output logic                         out_last,
  output logic                         busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [LW-1:0] MAX_LEN = LW'(NUM_SLICE - 1);

  state_t                         state_q;
  logic [SLICE_W*NUM_SLICE-1:0]   data_q;
  logic [LW-1:0]                  len_q;
  logic                           out_valid_q;
  logic [SLICE_W-1:0]             out_data_q;
  logic [LW-1:0]                  out_idx_q;
  logic                           out_last_q;
  logic                           busy_q;

  logic [SLICE_W-1:0] in_slice  [NUM_SLICE];
  logic [SLICE_W-1:0] buf_slice [NUM_SLICE];
  logic [LW-1:0]      len_d;
  logic [LW-1:0]      first_idx_d;
  logic [LW-1:0]      next_idx_d;
  logic               next_last_d;
  logic               accept;
  logic               fire;

  for (genvar gi = 0; gi < NUM_SLICE; gi++) begin : g_slice
    assign in_slice[gi]  = in_data[gi*SLICE_W +: SLICE_W];
    assign buf_slice[gi] = data_q[gi*SLICE_W +: SLICE_W];
  end

  // A power-of-two slice count can never see an out-of-range length.
  if ((1 << LW) == NUM_SLICE) begin : g_noclamp
    assign len_d = in_len;
  end else begin : g_clamp
    assign len_d = (in_len > MAX_LEN) ? MAX_LEN : in_len;
  end

  assign fire        = out_valid_q & out_ready;
  assign in_ready    = (state_q == IDLE) | (fire & out_last_q);
  assign accept      = in_valid & in_ready;
  assign first_idx_d = (MSB_FIRST != 0) ? len_d : '0;
  assign next_idx_d  = (MSB_FIRST != 0) ? (out_idx_q - 1'b1) : (out_idx_q + 1'b1);
  assign next_last_d = (MSB_FIRST != 0) ? (next_idx_d == '0) : (next_idx_d == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      // First slice comes straight from the input so it is visible one cycle later.
      state_q     <= SEND;
      data_q      <= in_data;
      len_q       <= len_d;
      out_valid_q <= 1'b1;
      out_data_q  <= in_slice[first_idx_d];
      out_idx_q   <= first_idx_d;
      out_last_q  <= (len_d == '0);
      busy_q      <= 1'b1;
    end else if (fire) begin
      if (out_last_q) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        out_data_q <= buf_slice[next_idx_d];
        out_idx_q  <= next_idx_d;
        out_last_q <= next_last_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: doc/vec_ser.md
VEC_SER -- requirements
Module: vec_ser

Interface
REQ-001 SHALL have parameter SLICE_W, default 32, meaning the width of one output slice in bits.
REQ-002 SHALL have parameter NUM_SLICE, default 32, meaning the number of slices held in one input vector (>=2).
REQ-003 SHALL have parameter MSB_FIRST, default 0, meaning the emission order: 0 = ascending slice index, 1 = descending.
REQ-004 SHALL derive LW = $clog2(NUM_SLICE) as the width of the length and index fields.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port in_valid  input  1  an input vector is offered.
REQ-009 SHALL have port in_ready  output  1  the block accepts a vector this cycle.
REQ-010 SHALL have port in_data  input  SLICE_W*NUM_SLICE  input vector; slice k = in_data[k*SLICE_W +: SLICE_W].
REQ-011 SHALL have port in_len  input  LW  number of slices to emit, minus 1.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid slice.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the slice.
REQ-014 SHALL have port out_data  output  SLICE_W  current slice.
REQ-015 SHALL have port out_idx  output  LW  slice index of out_data.
REQ-016 SHALL have port out_last  output  1  current slice is the final slice of the frame.
REQ-017 SHALL have port busy  output  1  a frame is in progress (state SEND).

Function
REQ-018 SHALL implement an FSM with states IDLE and SEND.
REQ-019 SHALL drive in_ready = (state==IDLE) | (out_valid & out_ready & out_last), combinationally.
REQ-020 SHALL accept a vector on in_valid & in_ready: register in_data and in_len, then move to SEND.
REQ-021 SHALL clamp a registered in_len greater than NUM_SLICE-1 to NUM_SLICE-1.
REQ-022 SHALL assert out_valid the cycle after acceptance (latency 1), with the first slice presented.
REQ-023 SHALL, when MSB_FIRST=0, emit indices 0,1,...,len; when MSB_FIRST=1, emit len,len-1,...,0.
REQ-024 SHALL hold out_data, out_idx and out_last stable while out_valid & !out_ready.
REQ-025 SHALL advance to the next slice on each out_valid & out_ready; it never skips or repeats a slice.
REQ-026 SHALL assert out_last exactly on the final slice of the frame (index len, or index 0 when MSB_FIRST=1).
REQ-027 SHALL, on a last-slice handshake with no new acceptance, deassert out_valid and go to IDLE next cycle.
REQ-028 SHALL, on a last-slice handshake in the same cycle as a new acceptance, present the new frame's first slice next cycle, with no bubble.
REQ-029 SHALL, with in_len=0, emit a single slice with out_last=1.
REQ-030 SHALL ignore in_data, in_len and in_valid changes while in SEND until the last-slice handshake.
REQ-031 SHALL keep out_data at its last value when out_valid=0; downstream treats it as don't-care.

Reset
REQ-032 SHALL, on rst_n=0 and independent of clk, force state to IDLE and set out_valid, out_data, out_idx, out_last and busy to 0.
REQ-033 SHALL discard any partial frame on reset mid-operation; no further slices of it appear after release.
REQ-034 SHALL allow in_ready=1 from the first cycle after rst_n deasserts.

Verification
REQ-035 Defaults, 32 random words loaded, in_len=31, out_ready=1 -> 32 consecutive beats, out_data = word k with out_idx=k on beat k, out_last only on beat 31.
REQ-036 MSB_FIRST=1, in_len=3, in_data slices 0..3 = 0xA,0xB,0xC,0xD -> out_data sequence 0xD,0xC,0xB,0xA, out_idx 3,2,1,0, out_last on 0xA.
REQ-037 Backpressure: out_ready toggles 1,0,0,1 each beat -> out_data stable during stalls, no slice lost or duplicated, beat count = in_len+1.
REQ-038 Back-to-back: in_valid held high over two frames with in_len=1 -> in_ready high on the last-beat handshake, 4 beats with out_valid high continuously, out_last on beats 1 and 3.
REQ-039 NUM_SLICE=5, in_len=7 -> clamped, 5 beats emitted, out_last on idx 4.
REQ-040 rst_n pulsed low on beat 10 of a 32-slice frame -> out_valid=0 and busy=0 immediately, in_ready=1 the cycle after release, no stale slices emitted.
